// File: rtl/charge_state_controller.sv
// charge_state_controller: synchronises AWG control lines, counts photon edges inside
// gated windows, classifies each window against latched thresholds and tracks
// sequence position and repeat-until-success attempts.
// Optional window timeout: define CHARGE_CTRL_WIN_TIMEOUT_EN to enable it.
module charge_state_controller #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned THR_W       = 8,
    parameter int unsigned SEQ_W       = 6,
    parameter int unsigned ATT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIN_TIMEOUT = 65535
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESET,
    input  logic             enable,
    input  logic             soft_reset,
    input  logic             count_on,
    input  logic             photon_in,
    input  logic             seq_tick,
    input  logic [1:0]       mode,
    input  logic [THR_W-1:0] thr_lo,
    input  logic [THR_W-1:0] thr_hi,
    input  logic [ATT_W-1:0] max_attempts,
    output logic             count_start,
    output logic             count_done,
    output logic             thr_hit,
    output logic             give_up,
    output logic [CNT_W-1:0] counts_out,
    output logic [SEQ_W-1:0] seq_pos,
    output logic [ATT_W-1:0] attempts,
    output logic             overflow,
    output logic             timeout,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StArmed    = 2'd1,
        StCounting = 2'd2,
        StDone     = 2'd3
    } state_t;

    // Synchroniser chain, bit order {seq_tick, photon_in, count_on, soft_reset, enable}
    logic [4:0]                  w_async_in;
    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic [4:0]                  w_sync;
    // Previous synced level of {seq_tick, photon_in, count_on} for edge detection
    logic [2:0]                  r_edge_prev;

    logic w_en, w_srst, w_con, w_ph, w_tick;
    logic w_con_rise, w_con_fall, w_ph_rise, w_tick_rise;

    state_t           r_state;
    logic [CNT_W-1:0] r_counts;
    logic [SEQ_W-1:0] r_seq;
    logic [ATT_W-1:0] r_attempts;
    logic             r_overflow;
    logic             r_thr_hit;
    logic             r_count_start;
    logic             r_count_done;
    logic             r_give_up;
    logic [1:0]       r_mode;
    logic [THR_W-1:0] r_thr_lo;
    logic [THR_W-1:0] r_thr_hi;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_cnt_ovf;
    logic [CNT_W-1:0] w_lo_ext;
    logic [CNT_W-1:0] w_hi_ext;
    logic             w_dyn_stop;
    logic             w_normal_end;
    logic             w_timeout_end;
    logic             w_end;
    logic             w_hit;
    logic             w_hit_final;
    logic [ATT_W-1:0] w_att_inc;
    logic             w_give_up;
    logic             w_seq_adv;

    assign w_async_in = {seq_tick, photon_in, count_on, soft_reset, enable};
    assign w_sync     = r_sync[SYNC_STAGES-1];

    assign w_en   = w_sync[0];
    assign w_srst = w_sync[1];
    assign w_con  = w_sync[2];
    assign w_ph   = w_sync[3];
    assign w_tick = w_sync[4];

    assign w_con_rise  = w_con & ~r_edge_prev[0];
    assign w_con_fall  = ~w_con & r_edge_prev[0];
    assign w_ph_rise   = w_ph & ~r_edge_prev[1];
    assign w_tick_rise = w_tick & ~r_edge_prev[2];

    // Shift async inputs through the synchroniser and keep one extra stage for edges
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_sync      <= '0;
            r_edge_prev <= '0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], w_async_in};
            r_edge_prev <= w_sync[4:2];
        end
    end

    // Saturating photon increment; a photon in the window-ending clock is still counted
    assign w_cnt_ovf  = w_ph_rise & (&r_counts);
    assign w_cnt_next = (w_ph_rise && !(&r_counts)) ? r_counts + CNT_W'(1) : r_counts;

    assign w_lo_ext = CNT_W'(r_thr_lo);
    assign w_hi_ext = CNT_W'(r_thr_hi);

    // Dynamic stop looks at the registered count, so it ends the clock after the increment
    assign w_dyn_stop   = (r_mode == 2'b00) && (r_counts >= w_lo_ext);
    assign w_normal_end = w_dyn_stop | w_con_fall;
    assign w_end        = w_normal_end | w_timeout_end;

    // Window classification on the final count
    always_comb begin
        w_hit = 1'b0;
        unique case (r_mode)
            2'b00:   w_hit = (w_cnt_next >= w_lo_ext);
            2'b01:   w_hit = (w_cnt_next >= w_lo_ext) && (w_cnt_next <= w_hi_ext);
            2'b10:   w_hit = (w_cnt_next < w_lo_ext);
            default: w_hit = (w_cnt_next >= w_lo_ext);
        endcase
    end

    assign w_hit_final = w_hit & ~w_timeout_end;
    assign w_att_inc   = (&r_attempts) ? r_attempts : r_attempts + ATT_W'(1);
    assign w_give_up   = (max_attempts != '0) && (w_att_inc == max_attempts);
    assign w_seq_adv   = w_tick_rise & w_en & (r_state != StCounting) & ~w_con_rise;

`ifdef CHARGE_CTRL_WIN_TIMEOUT_EN
    localparam int unsigned WinCntW = $clog2(WIN_TIMEOUT + 1);

    logic [WinCntW-1:0] r_win_cnt;
    logic               r_timeout;

    assign w_timeout_end = (r_state == StCounting) && !w_normal_end &&
                           (r_win_cnt == WinCntW'(WIN_TIMEOUT - 1));
    assign timeout       = r_timeout;

    // Window length counter and sticky timeout flag
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_win_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (w_srst) begin
            r_win_cnt <= '0;
            r_timeout <= 1'b0;
        end else if (w_en && r_state == StCounting) begin
            r_win_cnt <= r_win_cnt + WinCntW'(1);
            if (w_timeout_end) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_win_cnt <= '0;
        end
    end
`else
    logic w_unused_win_timeout;

    assign w_unused_win_timeout = |WIN_TIMEOUT;
    assign w_timeout_end        = 1'b0;
    assign timeout              = 1'b0;
`endif

    // Main FSM with all registered outputs
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state       <= StIdle;
            r_counts      <= '0;
            r_seq         <= '0;
            r_attempts    <= '0;
            r_overflow    <= 1'b0;
            r_thr_hit     <= 1'b0;
            r_count_start <= 1'b0;
            r_count_done  <= 1'b0;
            r_give_up     <= 1'b0;
            r_mode        <= '0;
            r_thr_lo      <= '0;
            r_thr_hi      <= '0;
        end else begin
            r_count_start <= 1'b0;
            r_count_done  <= 1'b0;
            r_give_up     <= 1'b0;
            if (w_srst) begin
                r_state    <= StIdle;
                r_counts   <= '0;
                r_seq      <= '0;
                r_attempts <= '0;
                r_overflow <= 1'b0;
                r_thr_hit  <= 1'b0;
            end else if (!w_en) begin
                // Abandon any window silently; counters keep their values
                r_state <= StIdle;
            end else begin
                if (w_seq_adv) begin
                    r_seq <= r_seq + SEQ_W'(1);
                end
                unique case (r_state)
                    StIdle: begin
                        r_state <= StArmed;
                    end
                    StArmed: begin
                        if (w_con_rise) begin
                            r_state       <= StCounting;
                            r_counts      <= '0;
                            r_count_start <= 1'b1;
                            r_thr_hit     <= 1'b0;
                            r_mode        <= mode;
                            r_thr_lo      <= thr_lo;
                            r_thr_hi      <= thr_hi;
                        end
                    end
                    StCounting: begin
                        r_counts <= w_cnt_next;
                        if (w_cnt_ovf) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_end) begin
                            r_state      <= StDone;
                            r_count_done <= 1'b1;
                            r_thr_hit    <= w_hit_final;
                            if (w_hit_final) begin
                                r_attempts <= '0;
                            end else if (w_give_up) begin
                                r_give_up  <= 1'b1;
                                r_attempts <= '0;
                            end else begin
                                r_attempts <= w_att_inc;
                            end
                        end
                    end
                    default: begin
                        if (!w_con) begin
                            r_state <= StArmed;
                        end
                    end
                endcase
            end
        end
    end

    assign count_start = r_count_start;
    assign count_done  = r_count_done;
    assign thr_hit     = r_thr_hit;
    assign give_up     = r_give_up;
    assign counts_out  = r_counts;
    assign seq_pos     = r_seq;
    assign attempts    = r_attempts;
    assign overflow    = r_overflow;
    assign state_out   = r_state;

endmodule

// File: tb/tb_charge_state_controller.sv
// Randomised self-checking bench for charge_state_controller (CNT_W=4 so saturation is reachable).
module tb_charge_state_controller;

    localparam int CNT_W   = 4;
    localparam int THR_W   = 4;
    localparam int SEQ_W   = 6;
    localparam int ATT_W   = 8;
    localparam int SYNC    = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int ATT_MAX = (1 << ATT_W) - 1;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             soft_reset;
    logic             count_on;
    logic             photon_in;
    logic             seq_tick;
    logic [1:0]       mode;
    logic [THR_W-1:0] thr_lo;
    logic [THR_W-1:0] thr_hi;
    logic [ATT_W-1:0] max_attempts;
    logic             count_start;
    logic             count_done;
    logic             thr_hit;
    logic             give_up;
    logic [CNT_W-1:0] counts_out;
    logic [SEQ_W-1:0] seq_pos;
    logic [ATT_W-1:0] attempts;
    logic             overflow;
    logic             timeout;
    logic [1:0]       state_out;

    charge_state_controller #(
        .CNT_W      (CNT_W),
        .THR_W      (THR_W),
        .SEQ_W      (SEQ_W),
        .ATT_W      (ATT_W),
        .SYNC_STAGES(SYNC),
        .WIN_TIMEOUT(65535)
    ) u_dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .enable      (enable),
        .soft_reset  (soft_reset),
        .count_on    (count_on),
        .photon_in   (photon_in),
        .seq_tick    (seq_tick),
        .mode        (mode),
        .thr_lo      (thr_lo),
        .thr_hi      (thr_hi),
        .max_attempts(max_attempts),
        .count_start (count_start),
        .count_done  (count_done),
        .thr_hit     (thr_hit),
        .give_up     (give_up),
        .counts_out  (counts_out),
        .seq_pos     (seq_pos),
        .attempts    (attempts),
        .overflow    (overflow),
        .timeout     (timeout),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept at the level of windows, not clocks
    int m_att = 0;
    int m_seq = 0;
    int m_ovf = 0;

    // Pulse monitor
    int n_start = 0;
    int n_done  = 0;
    int snap_cnt, snap_hit, snap_gu, snap_att;

    always @(negedge clk) begin
        if (count_start === 1'b1) n_start++;
        if (count_done === 1'b1) begin
            n_done++;
            snap_cnt = int'(counts_out);
            snap_hit = int'(thr_hit);
            snap_gu  = int'(give_up);
            snap_att = int'(attempts);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_photons(input int n);
        for (int i = 0; i < n; i++) begin
            photon_in = 1'b1;
            step(2);
            photon_in = 1'b0;
            step(2);
        end
    endtask

    task automatic do_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            seq_tick = 1'b1;
            step(2);
            seq_tick = 1'b0;
            step(2);
        end
        step(SYNC + 2);
        m_seq = (m_seq + k) % (1 << SEQ_W);
        check("seq_pos", 32'(seq_pos), 32'(m_seq));
    endtask

    // One complete window; expected result derived from the decision rules
    task automatic run_window(input int m, input int lo, input int hi, input int nph,
                              input int max_a, input bit scramble);
        int s0, d0, cnt, hit, gu, inc, ovf_now;
        mode         = 2'(m);
        thr_lo       = THR_W'(lo);
        thr_hi       = THR_W'(hi);
        max_attempts = ATT_W'(max_a);
        check("armed_before_window", 32'(state_out), 32'd1);
        s0 = n_start;
        d0 = n_done;
        count_on = 1'b1;
        step(SYNC + 3);
        if (scramble) begin
            mode   = 2'($urandom);
            thr_lo = THR_W'($urandom);
            thr_hi = THR_W'($urandom);
        end
        pulse_photons(nph);
        step(2);
        count_on = 1'b0;
        step(SYNC + 4);

        cnt     = (nph > CNT_MAX) ? CNT_MAX : nph;
        ovf_now = (nph > CNT_MAX) ? 1 : 0;
        case (m)
            0: begin
                if (nph >= lo) begin
                    cnt     = lo;
                    hit     = 1;
                    ovf_now = 0;
                end else begin
                    hit = 0;
                end
            end
            1:       hit = (lo <= cnt && cnt <= hi) ? 1 : 0;
            2:       hit = (cnt < lo) ? 1 : 0;
            default: hit = (cnt >= lo) ? 1 : 0;
        endcase
        gu = 0;
        if (hit != 0) begin
            m_att = 0;
        end else begin
            inc = (m_att + 1 > ATT_MAX) ? ATT_MAX : m_att + 1;
            if (max_a != 0 && inc == max_a) begin
                gu    = 1;
                m_att = 0;
            end else begin
                m_att = inc;
            end
        end
        if (ovf_now != 0) m_ovf = 1;

        check("start_pulses", 32'(n_start - s0), 32'd1);
        check("done_pulses", 32'(n_done - d0), 32'd1);
        check("counts_at_done", 32'(snap_cnt), 32'(cnt));
        check("hit_at_done", 32'(snap_hit), 32'(hit));
        check("give_up_at_done", 32'(snap_gu), 32'(gu));
        check("attempts_at_done", 32'(snap_att), 32'(m_att));
        check("counts_frozen", 32'(counts_out), 32'(cnt));
        check("thr_hit_held", 32'(thr_hit), 32'(hit));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("state_after_window", 32'(state_out), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_counts"}, 32'(counts_out), 32'd0);
        check({tag, "_seq"}, 32'(seq_pos), 32'd0);
        check({tag, "_attempts"}, 32'(attempts), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_thr_hit"}, 32'(thr_hit), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_state"}, 32'(state_out), 32'd0);
        check({tag, "_pulses"}, 32'({count_start, count_done, give_up}), 32'd0);
    endtask

    initial begin
        int d0, s0;
        rst          = 1'b1;
        enable       = 1'b0;
        soft_reset   = 1'b0;
        count_on     = 1'b0;
        photon_in    = 1'b0;
        seq_tick     = 1'b0;
        mode         = 2'd0;
        thr_lo       = '0;
        thr_hi       = '0;
        max_attempts = '0;
        step(3);
        check_cleared("reset");
        rst = 1'b0;
        step(3);
        check("idle_while_disabled", 32'(state_out), 32'd0);
        enable = 1'b1;
        step(SYNC + 3);
        check("armed_after_enable", 32'(state_out), 32'd1);

        // Directed windows
        run_window(3, 5, 0, 7, 0, 1'b0);
        run_window(0, 3, 0, 10, 0, 1'b0);
        run_window(1, 2, 4, 1, 0, 1'b0);
        run_window(1, 2, 4, 3, 0, 1'b0);
        run_window(1, 2, 4, 5, 0, 1'b0);
        run_window(3, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) run_window(3, 10, 0, 0, 3, 1'b0);
        run_window(2, 1, 0, 0, 0, 1'b0);
        run_window(0, 0, 0, 4, 0, 1'b0);

        // Randomised windows with threshold changes mid-window
        for (int i = 0; i < 40; i++) begin
            do_ticks($urandom_range(0, 4));
            run_window($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 13), $urandom_range(0, 4), 1'b1);
        end

        // Saturation, sticky through the next window
        run_window(3, 5, 0, 20, 0, 1'b0);
        run_window(3, 5, 0, 5, 0, 1'b0);

        // Enable drop mid-window: counts hold, no done pulse
        s0 = n_start;
        d0 = n_done;
        count_on = 1'b1;
        step(SYNC + 3);
        pulse_photons(3);
        step(SYNC + 2);
        enable = 1'b0;
        step(SYNC + 3);
        check("disable_state", 32'(state_out), 32'd0);
        check("disable_counts_hold", 32'(counts_out), 32'd3);
        count_on = 1'b0;
        step(SYNC + 3);
        check("disable_no_done", 32'(n_done - d0), 32'd0);
        check("disable_one_start", 32'(n_start - s0), 32'd1);
        check("disable_attempts", 32'(attempts), 32'(m_att));
        enable = 1'b1;
        step(SYNC + 3);
        check("reenable_armed", 32'(state_out), 32'd1);

        // Soft clear, then 70 ticks, then soft clear mid-window
        soft_reset = 1'b1;
        step(SYNC + 2);
        check_cleared("soft_reset");
        soft_reset = 1'b0;
        m_att = 0;
        m_seq = 0;
        m_ovf = 0;
        step(SYNC + 3);
        check("armed_after_soft_reset", 32'(state_out), 32'd1);
        do_ticks(70);
        d0 = n_done;
        count_on = 1'b1;
        step(SYNC + 3);
        pulse_photons(2);
        soft_reset = 1'b1;
        step(SYNC + 2);
        check_cleared("mid_window_clear");
        count_on = 1'b0;
        step(4);
        soft_reset = 1'b0;
        step(SYNC + 3);
        check("clear_no_done", 32'(n_done - d0), 32'd0);
        check("armed_after_clear", 32'(state_out), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/charge_state_controller.md
Name: charge_state_controller

Overview:
- Parametrised successor to the single-window charge-control block: counts photon edges during AWG-gated windows, classifies each window against programmable thresholds, and returns trigger, result and count data to the AWG/DAQ.
- All asynchronous AWG lines are synchronised into one clock domain; a proper FSM replaces edge-clocked counters.
- Adds four decision modes, saturating counters, attempt counting for repeat-until-success charge initialisation, and per-window threshold latching.

Parameters:
- CNT_W, 8, photon counter width
- THR_W, 8, threshold width (must be <= CNT_W)
- SEQ_W, 6, sequence-position counter width
- ATT_W, 8, attempt counter width
- SYNC_STAGES, 2, synchroniser depth for async inputs (>= 2)
- WIN_TIMEOUT, 65535, max window length in clocks (used only with the optional feature)

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESET  in  1  reset; asynchronous, active-high
- enable  in  1  async; block active when high
- soft_reset  in  1  async; synchronised clear from AWG
- count_on  in  1  async; counting window gate
- photon_in  in  1  async; detector pulses, rising edge counts
- seq_tick  in  1  async; sequence-line advance, rising edge
- mode  in  2  00 dynamic stop, 01 window classify, 10 dark detect, 11 end-of-window threshold
- thr_lo  in  THR_W  lower threshold
- thr_hi  in  THR_W  upper threshold (mode 01 only)
- max_attempts  in  ATT_W  0 = unlimited
- count_start  out  1  one-clock pulse at window start
- count_done  out  1  one-clock pulse at window end
- thr_hit  out  1  result of last window; level, held until next window start
- give_up  out  1  one-clock pulse when attempts reaches max_attempts
- counts_out  out  CNT_W  live or frozen photon count
- seq_pos  out  SEQ_W  sequence position
- attempts  out  ATT_W  failed windows since last hit or clear
- overflow  out  1  sticky; photon counter saturated
- timeout  out  1  sticky; window aborted by timeout
- state_out  out  2  FSM state encoding

Behaviour:
- S_AXI_ARESET: every output and register goes to 0 immediately; FSM enters IDLE.
- Synchronisation:
  - enable, soft_reset, count_on, photon_in and seq_tick each pass through SYNC_STAGES flops.
  - Rising and falling edges are detected with one further flop.
  - Input-to-effect latency is SYNC_STAGES+1 clocks; counts_out changes SYNC_STAGES+1 clocks after a photon rising edge.
- soft_reset (synced level) is a synchronous clear with priority over everything else:
  - counts, seq_pos, attempts, overflow, timeout and thr_hit are cleared.
  - FSM goes to IDLE.
  - No pulse outputs fire.
- FSM (state_out: IDLE=0, ARMED=1, COUNTING=2, DONE=3):
  - IDLE -> ARMED when enable is high.
  - Any state -> IDLE when enable is low. Counters hold their values; no count_done pulse is generated.
  - ARMED -> COUNTING on a count_on rising edge:
    - counts clears to 0 and count_start pulses.
    - thr_lo, thr_hi and mode are latched; changes during the window are ignored.
    - thr_hit clears.
  - COUNTING:
    - Each photon rising edge increments counts, saturating at all-ones and setting overflow.
    - A photon edge in the same clock as the window-ending event is counted.
  - Window end, COUNTING -> DONE, count_done pulses:
    - mode 00: ends when counts >= thr_lo (the clock after the threshold-reaching increment, thr_hit=1), or at count_on fall (thr_hit=0).
    - mode 01: ends at count_on fall; thr_hit = (thr_lo <= counts <= thr_hi). If thr_lo > thr_hi, thr_hit=0.
    - mode 10: ends at count_on fall; thr_hit = (counts < thr_lo).
    - mode 11: ends at count_on fall; thr_hit = (counts >= thr_lo).
  - DONE:
    - counts is frozen; photon edges are ignored.
    - DONE -> ARMED once count_on is low, immediately if it is already low.
- Attempts:
  - At window end, thr_hit=1 clears attempts.
  - thr_hit=0 increments attempts, saturating at all-ones.
  - If max_attempts != 0 and the incremented value equals max_attempts, give_up pulses in the same clock as count_done and attempts clears.
- seq_pos:
  - Increments on a seq_tick rising edge only when enable is high and the state is not COUNTING.
  - Wraps modulo 2^SEQ_W.
  - The edge is dropped if it coincides with a count_on rising edge.
- Outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro CHARGE_CTRL_WIN_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in COUNTING.
  - If the window lasts WIN_TIMEOUT clocks without ending, it is forced to end: count_done pulses, thr_hit=0, the attempt is recorded as failed, and sticky timeout is set.
  - The FSM then waits in DONE for count_on to go low.
- Not defined: timeout is tied to 0, no counter is synthesised, and windows end only as above.

Test Plan:
- Mode 11, thr_lo=5: 7 photon pulses in the window then count_on falls -> count_done pulse, counts_out=7, thr_hit=1, attempts=0.
- Mode 00, thr_lo=3: 10 photons in the window -> window ends after the 3rd edge, counts_out=3 frozen, thr_hit=1; remaining edges ignored.
- Mode 01, thr_lo=2, thr_hi=4: windows with 1, 3 and 5 photons -> thr_hit 0, 1, 0; attempts goes 1, 0, 1.
- max_attempts=3, mode 11, thr_lo=10: three windows with 0 photons -> give_up pulses with the third count_done, attempts=0.
- CNT_W=4: 20 photons in one window -> counts_out=15, overflow=1 sticky through the next window.
- 70 seq_tick edges outside windows with SEQ_W=6, then soft_reset mid-window -> seq_pos=6 before the reset; after reset, all outputs 0, state_out=IDLE, then ARMED while enable stays high.
